alu_result_fifo: RTL and testbench
==================================

// Module: alu_result_fifo
// PURPOSE
//  Downstream stage of the 8-bit ALU: captures each valid result (16-bit OUT + OV flag)
//  into a first-word-fall-through FIFO and presents it on a valid/ready interface to
//  the consumer. Keeps saturating counters of dropped results and of overflowed results.
//  Sits between the ALU result outputs and the scoreboard/host read logic.
// PARAMETERS
//  DEPTH  8   FIFO entries; power of 2, >= 2
//  DW     16  result data width; matches ALU OUT
//  CNT_W  8   width of DROP_CNT and OV_CNT
// PORTS
//  CLK       in   1                  single clock, rising edge
//  RST_N     in   1                  asynchronous active-low reset
//  IN_VLD    in   1                  ALU result valid this cycle
//  IN_DATA   in   DW                 ALU result (OUT)
//  IN_OV     in   1                  ALU overflow flag for this result
//  OUT_VLD   out  1                  head entry available
//  OUT_RDY   in   1                  consumer accepts head entry
//  OUT_DATA  out  DW                 head entry data
//  OUT_OV    out  1                  head entry overflow flag
//  FULL      out  1                  LEVEL == DEPTH
//  EMPTY     out  1                  LEVEL == 0
//  LEVEL     out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//  CLR_CNT   in   1                  synchronous clear of DROP_CNT and OV_CNT
//  DROP_CNT  out  CNT_W              results lost because FIFO full
//  OV_CNT    out  CNT_W              accepted results with IN_OV=1
// BEHAVIOUR
//  - Reset (RST_N low, async): pointers, LEVEL, DROP_CNT, OV_CNT -> 0; EMPTY=1, FULL=0,
//    OUT_VLD=0, OUT_DATA=0, OUT_OV=0. Takes effect immediately, mid-stream included;
//    all stored entries are discarded. Storage array needs no reset.
//  - pop  = OUT_VLD & OUT_RDY.
//  - push = IN_VLD & (!FULL | pop). Full FIFO with a pop in the same cycle accepts the push.
//  - drop = IN_VLD & FULL & !pop.
//  - Entry stored = {IN_OV, IN_DATA}; write at wr_ptr, read at rd_ptr; both wrap mod DEPTH.
//  - LEVEL: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - Latency: a push in cycle t is visible on OUT_VLD/OUT_DATA in cycle t+1. No
//    combinational bypass; an empty FIFO never asserts OUT_VLD in the push cycle.
//  - OUT_VLD = !EMPTY. OUT_DATA/OUT_OV show the head entry when OUT_VLD=1; driven to 0
//    when OUT_VLD=0. Head is held stable while OUT_VLD=1 & OUT_RDY=0.
//  - OUT_RDY when EMPTY: ignored, no state change.
//  - FULL, EMPTY, LEVEL are registered values (reflect state after the last edge).
//  - DROP_CNT: +1 per drop cycle, saturates at 2^CNT_W-1.
//  - OV_CNT: +1 per push with IN_OV=1, saturates at 2^CNT_W-1. Dropped results never
//    count toward OV_CNT.
//  - CLR_CNT=1: both counters -> 0 at the next edge; clear wins over a same-cycle
//    increment (result 0). FIFO contents are unaffected by CLR_CNT.
//  - IN_* are don't-care when IN_VLD=0; OUT_RDY is don't-care when OUT_VLD=0.
// TESTING
//  1. Assert RST_N low with 3 entries held -> next sample: LEVEL=0, EMPTY=1, OUT_VLD=0,
//     OUT_DATA=0, counters 0; after release, a push of 0x00AA appears at head 1 cycle later.
//  2. OUT_RDY=0; push 0x0001..0x0008 -> FULL=1, LEVEL=8; push 0x0009 -> DROP_CNT=1, LEVEL=8;
//     then OUT_RDY=1 -> reads 0x0001..0x0008 in order; EMPTY=1 after 8 pops.
//  3. Empty FIFO, OUT_RDY=1 held; push 0x1234 at cycle t -> OUT_VLD=1, OUT_DATA=0x1234 at
//     t+1; popped at t+1; EMPTY=1 at t+2.
//  4. FIFO full, same cycle IN_VLD=1 (0xBEEF) and OUT_RDY=1 -> LEVEL stays 8,
//     DROP_CNT unchanged; 0xBEEF is read 8th after the pop.
//  5. 300 accepted pushes with IN_OV=1 -> OV_CNT=255 (saturated); CLR_CNT=1 together with
//     an IN_OV=1 push -> OV_CNT=0 next cycle and that entry still stored with OUT_OV=1.
//  6. Random IN_VLD/OUT_RDY (~50% each) for 1000 cycles -> output order equals accepted
//     input order across many pointer wraps; DROP_CNT equals model count of drop cycles.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
// First-word-fall-through buffer behind the 8-bit ALU. Each valid result
// {IN_OV, IN_DATA} is queued and presented on a valid/ready interface.
// Saturating counters track results lost to a full buffer and accepted
// results that carried the overflow flag.
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VLD,
  input  logic [DW-1:0]            IN_DATA,
  input  logic                     IN_OV,
  output logic                     OUT_VLD,
  input  logic                     OUT_RDY,
  output logic [DW-1:0]            OUT_DATA,
  output logic                     OUT_OV,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  input  logic                     CLR_CNT,
  output logic [CNT_W-1:0]         DROP_CNT,
  output logic [CNT_W-1:0]         OV_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    level_full = LW'(DEPTH);
  localparam logic [CNT_W-1:0] cnt_max    = '1;

  // Each entry keeps the overflow flag in the top bit above the data.
  logic [DW:0]      mem [DEPTH];
  logic [DW:0]      head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_nxt;
  logic             full_q;
  logic             empty_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] ov_cnt_q;
  logic             out_vld;
  logic             pop;
  logic             push;
  logic             drop;

  // The head is only ever valid from registered state, so a push into an
  // empty buffer shows up one cycle later with no combinational bypass.
  assign out_vld = !empty_q;
  assign pop     = out_vld & OUT_RDY;
  // A full buffer still takes a new result when the head leaves this cycle.
  assign push    = IN_VLD & (!full_q | pop);
  assign drop    = IN_VLD & full_q & !pop;
  assign head    = mem[rd_ptr];

  assign OUT_VLD  = out_vld;
  assign OUT_DATA = out_vld ? head[DW-1:0] : '0;
  assign OUT_OV   = out_vld & head[DW];
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign LEVEL    = level_q;
  assign DROP_CNT = drop_cnt_q;
  assign OV_CNT   = ov_cnt_q;

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    level_nxt = level_q;
    if (push && !pop) begin
      level_nxt = level_q + 1'b1;
    end else if (pop && !push) begin
      level_nxt = level_q - 1'b1;
    end
  end

  // Storage array is written only on accepted pushes and needs no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {IN_OV, IN_DATA};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy and the full/empty flags are registered together from level_nxt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      level_q <= level_nxt;
      full_q  <= (level_nxt == level_full);
      empty_q <= (level_nxt == '0);
    end
  end

  // Drop counter saturates; a same-cycle clear takes priority over a drop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_q <= '0;
    end else if (CLR_CNT) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != cnt_max)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // Overflow counter only counts accepted results; clear wins here too.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ov_cnt_q <= '0;
    end else if (CLR_CNT) begin
      ov_cnt_q <= '0;
    end else if (push && IN_OV && (ov_cnt_q != cnt_max)) begin
      ov_cnt_q <= ov_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo
// Directed checks of the ALU result buffer followed by a random valid/ready
// run against a small queue model.
module tb_alu_result_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int CNT_W = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VLD = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic          IN_OV = 1'b0;
  logic          OUT_RDY = 1'b0;
  logic          CLR_CNT = 1'b0;
  logic          OUT_VLD;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_OV;
  logic          FULL;
  logic          EMPTY;
  logic [3:0]    LEVEL;
  logic [CNT_W-1:0] DROP_CNT;
  logic [CNT_W-1:0] OV_CNT;

  int vectors = 0;
  int miscompares = 0;

  logic [DW:0] mq[$];
  int mdrop = 0;
  int mov = 0;

  alu_result_fifo #(.DEPTH(DEPTH), .DW(DW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VLD(IN_VLD), .IN_DATA(IN_DATA), .IN_OV(IN_OV),
    .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .OUT_DATA(OUT_DATA), .OUT_OV(OUT_OV),
    .FULL(FULL), .EMPTY(EMPTY), .LEVEL(LEVEL),
    .CLR_CNT(CLR_CNT), .DROP_CNT(DROP_CNT), .OV_CNT(OV_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the reference queue.
  task automatic applyStimulus(input logic vld, input logic [DW-1:0] d, input logic ov,
                               input logic rdy, input logic clr);
    bit mpop, mpush, mdropc, mfull;
    IN_VLD  = vld;
    IN_DATA = d;
    IN_OV   = ov;
    OUT_RDY = rdy;
    CLR_CNT = clr;
    mfull  = (mq.size() == DEPTH);
    mpop   = (mq.size() != 0) && rdy;
    mpush  = vld && (!mfull || mpop);
    mdropc = vld && mfull && !mpop;
    @(posedge CLK);
    #1;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back({ov, d});
    if (clr) begin
      mdrop = 0;
      mov = 0;
    end else begin
      if (mdropc && mdrop < 255) mdrop++;
      if (mpush && ov && mov < 255) mov++;
    end
  endtask

  task automatic checkModel(input string tag);
    logic [DW:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    checkOutput({tag, "_level"}, 32'(LEVEL), 32'(mq.size()));
    checkOutput({tag, "_vld"}, 32'(OUT_VLD), 32'(mq.size() != 0));
    checkOutput({tag, "_data"}, 32'(OUT_DATA), 32'(h[DW-1:0]));
    checkOutput({tag, "_ov"}, 32'(OUT_OV), 32'(h[DW]));
    checkOutput({tag, "_full"}, 32'(FULL), 32'(mq.size() == DEPTH));
    checkOutput({tag, "_drop"}, 32'(DROP_CNT), 32'(mdrop));
    checkOutput({tag, "_ovcnt"}, 32'(OV_CNT), 32'(mov));
  endtask

  initial begin
    // Power-on reset state
    #12;
    checkOutput("por_level", 32'(LEVEL), 32'd0);
    checkOutput("por_empty", 32'(EMPTY), 32'd1);
    checkOutput("por_full", 32'(FULL), 32'd0);
    checkOutput("por_vld", 32'(OUT_VLD), 32'd0);
    checkOutput("por_data", 32'(OUT_DATA), 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Fill with 1..8 while the consumer stalls, then one dropped push
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("fill_full", 32'(FULL), 32'd1);
    checkOutput("fill_level", 32'(LEVEL), 32'd8);
    checkOutput("fill_head", 32'(OUT_DATA), 32'h0001);
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_cnt", 32'(DROP_CNT), 32'd1);
    checkOutput("drop_level", 32'(LEVEL), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain_data", 32'(OUT_DATA), 32'(i));
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(EMPTY), 32'd1);
    checkOutput("drain_vld", 32'(OUT_VLD), 32'd0);

    // Single push with the consumer always ready
    OUT_RDY = 1'b1;
    IN_VLD = 1'b1;
    IN_DATA = 16'h1234;
    #1;
    checkOutput("nobypass_vld", 32'(OUT_VLD), 32'd0);
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0);
    checkOutput("lat_vld", 32'(OUT_VLD), 32'd1);
    checkOutput("lat_data", 32'(OUT_DATA), 32'h1234);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("lat_empty", 32'(EMPTY), 32'd1);

    // Full buffer with a simultaneous push and pop
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(16'h0010 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("pp_head", 32'(OUT_DATA), 32'h0011);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    checkOutput("pp_level", 32'(LEVEL), 32'd8);
    checkOutput("pp_drop", 32'(DROP_CNT), 32'd1);
    checkOutput("pp_full", 32'(FULL), 32'd1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("pp_data", 32'(OUT_DATA), (k < 7) ? 32'(16'h0012 + k) : 32'h0000BEEF);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("pp_empty", 32'(EMPTY), 32'd1);

    // Asynchronous reset with three entries held
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, DW'(16'h00A0 + i), 1'b1, 1'b0, 1'b0);
    checkOutput("pre_rst_level", 32'(LEVEL), 32'd3);
    checkOutput("pre_rst_ovcnt", 32'(OV_CNT), 32'd3);
    IN_VLD = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("rst_level", 32'(LEVEL), 32'd0);
    checkOutput("rst_empty", 32'(EMPTY), 32'd1);
    checkOutput("rst_vld", 32'(OUT_VLD), 32'd0);
    checkOutput("rst_data", 32'(OUT_DATA), 32'd0);
    checkOutput("rst_drop", 32'(DROP_CNT), 32'd0);
    checkOutput("rst_ovcnt", 32'(OV_CNT), 32'd0);
    mq.delete();
    mdrop = 0;
    mov = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_vld", 32'(OUT_VLD), 32'd1);
    checkOutput("post_rst_data", 32'(OUT_DATA), 32'h00AA);
    checkOutput("post_rst_level", 32'(LEVEL), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Overflow counter saturation, then clear racing an overflowed push
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b1, 1'b0);
    checkOutput("ov_sat", 32'(OV_CNT), 32'd255);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("ov_drain_empty", 32'(EMPTY), 32'd1);
    applyStimulus(1'b1, 16'h0C0D, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_ovcnt", 32'(OV_CNT), 32'd0);
    checkOutput("clr_vld", 32'(OUT_VLD), 32'd1);
    checkOutput("clr_data", 32'(OUT_DATA), 32'h0C0D);
    checkOutput("clr_ov", 32'(OUT_OV), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checkModel("clr_after");

    // Random traffic against the queue model
    for (int c = 0; c < 1000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
      checkModel("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
